tcp_rd_pkg_gen: RTL and testbench

- Per-region generator of TCP read-package requests; one instance per region feeds one `s_rd_pkg[i]` input of the TCP RX arbiter.
- Buffers TCP receive notifications (session id + available bytes) and splits each one into read-package requests of at most MAX_PKG_BYTES.
- Limits the number of requests outstanding in the RX path with a credit counter. A credit is returned when the region's RX consumer signals that it has fully consumed a package (data tlast accepted).

---
 rtl/tcp_rd_pkg_gen_if.sv | 33 +++
 rtl/tcp_rd_pkg_gen.sv | 132 +++++++++++++
 tb/tb_tcp_rd_pkg_gen.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcp_rd_pkg_gen_if.sv
// Notification, read-package request and rx-done handshakes for one region.
interface tcp_rd_pkg_gen_if;
  logic        s_notify_valid;
  logic        s_notify_ready;
  logic [15:0] s_notify_sid;
  logic [15:0] s_notify_len;

  logic        m_rd_pkg_valid;
  logic        m_rd_pkg_ready;
  logic [15:0] m_rd_pkg_sid;
  logic [15:0] m_rd_pkg_len;

  logic        s_rx_done_valid;
  logic        s_rx_done_ready;

  modport slave (
    input  s_notify_valid, s_notify_sid, s_notify_len,
    output s_notify_ready,
    output m_rd_pkg_valid, m_rd_pkg_sid, m_rd_pkg_len,
    input  m_rd_pkg_ready,
    input  s_rx_done_valid,
    output s_rx_done_ready
  );

  modport master (
    output s_notify_valid, s_notify_sid, s_notify_len,
    input  s_notify_ready,
    input  m_rd_pkg_valid, m_rd_pkg_sid, m_rd_pkg_len,
    output m_rd_pkg_ready,
    output s_rx_done_valid,
    input  s_rx_done_ready
  );
endinterface

// File: rtl/tcp_rd_pkg_gen.sv
// Splits queued TCP rx notifications into read-package requests of <= MAX_PKG_BYTES; notify->request 2 cycles.
// Notify stalls only on a full queue; requests stall while MAX_OUTSTANDING packages are unconsumed.
module tcp_rd_pkg_gen #(
  parameter int MAX_PKG_BYTES   = 4096,
  parameter int MAX_OUTSTANDING = 4,
  parameter int NOTIFY_QDEPTH   = 16
) (
  input  logic                                   aclk,
  input  logic                                   areset,
  tcp_rd_pkg_gen_if.slave                        bus,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   err_underflow,
  output logic [31:0]                            drop_cnt
);

  localparam int              AW      = $clog2(NOTIFY_QDEPTH);
  localparam int              OW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [15:0]     MAX_LEN = 16'(MAX_PKG_BYTES);
  localparam logic [OW-1:0]   MAX_OUT = OW'(MAX_OUTSTANDING);

  typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [31:0]    r_mem [NOTIFY_QDEPTH];
  logic [AW:0]    r_wptr;
  logic [AW:0]    r_rptr;
  logic [15:0]    r_cur_sid;
  logic [15:0]    r_rem;
  logic [OW-1:0]  r_outstanding;
  logic           r_err_underflow;
  logic [31:0]    r_drop_cnt;

  logic           w_empty;
  logic           w_full;
  logic           w_push;
  logic           w_pop;
  logic [31:0]    w_head;
  logic [15:0]    w_chunk;
  logic           w_req_vld;
  logic           w_issue;
  logic           w_done;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = bus.s_notify_valid && bus.s_notify_ready;
  assign w_head  = r_mem[r_rptr[AW-1:0]];
  assign w_chunk = (r_rem < MAX_LEN) ? r_rem : MAX_LEN;
  assign w_issue = w_req_vld && bus.m_rd_pkg_ready;
  assign w_done  = bus.s_rx_done_valid;

  assign bus.s_notify_ready  = !w_full && !areset;
  assign bus.m_rd_pkg_valid  = w_req_vld;
  assign bus.m_rd_pkg_sid    = r_cur_sid;
  assign bus.m_rd_pkg_len    = w_chunk;
  assign bus.s_rx_done_ready = 1'b1;

  assign outstanding   = r_outstanding;
  assign err_underflow = r_err_underflow;
  assign drop_cnt      = r_drop_cnt;

  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= {bus.s_notify_sid, bus.s_notify_len};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_req_vld   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head[15:0] != 16'd0) begin
            w_state_nxt = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        w_req_vld = (r_outstanding < MAX_OUT);
        if (w_req_vld && bus.m_rd_pkg_ready && (r_rem == w_chunk)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state         <= ST_IDLE;
      r_wptr          <= '0;
      r_rptr          <= '0;
      r_cur_sid       <= '0;
      r_rem           <= '0;
      r_outstanding   <= '0;
      r_err_underflow <= 1'b0;
      r_drop_cnt      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        if (w_head[15:0] == 16'd0) begin
          r_drop_cnt <= r_drop_cnt + 32'd1;
        end else begin
          r_cur_sid <= w_head[31:16];
          r_rem     <= w_head[15:0];
        end
      end
      if (w_issue) begin
        r_rem <= r_rem - w_chunk;
      end
      // An issue and a done in the same cycle cancel; a lone done at zero is an error, not a wrap.
      if (w_issue && !w_done) begin
        r_outstanding <= r_outstanding + 1'b1;
      end else if (!w_issue && w_done) begin
        if (r_outstanding == '0) begin
          r_err_underflow <= 1'b1;
        end else begin
          r_outstanding <= r_outstanding - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tcp_rd_pkg_gen.sv
// Scoreboard bench for tcp_rd_pkg_gen: expected requests queued at notify time, compared at each request handshake.
module tb_tcp_rd_pkg_gen;

  localparam int PKG = 4096;

  typedef struct {
    logic [15:0] sid;
    logic [15:0] len;
  } req_t;

  logic        clk = 1'b0;
  logic        areset;
  logic [1:0]  outstanding;
  logic        err_underflow;
  logic [31:0] drop_cnt;

  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0;
  int   done_cnt = 0;
  int   base = 0;
  bit   auto_done = 1'b0;
  bit   man_done = 1'b0;
  req_t exp_q[$];

  tcp_rd_pkg_gen_if bus ();

  tcp_rd_pkg_gen #(
    .MAX_PKG_BYTES  (PKG),
    .MAX_OUTSTANDING(2),
    .NOTIFY_QDEPTH  (16)
  ) dut (
    .aclk         (clk),
    .areset       (areset),
    .bus          (bus),
    .outstanding  (outstanding),
    .err_underflow(err_underflow),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Request monitor: inputs change just after posedge, so negedge values are those seen by the next edge.
  always @(negedge clk) begin
    if (!areset && bus.m_rd_pkg_valid && bus.m_rd_pkg_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        chk_eq("spurious_req", 1, 0);
      end else begin
        req_t e;
        e = exp_q.pop_front();
        chk_eq("req_sid", bus.m_rd_pkg_sid, e.sid);
        chk_eq("req_len", bus.m_rd_pkg_len, e.len);
      end
    end
  end

  // Single driver of the done strobe: auto-return one done per accepted request, or a manual pulse.
  always @(posedge clk) begin
    #2;
    if (auto_done && (hs_cnt - done_cnt - base) > 0) begin
      bus.s_rx_done_valid = 1'b1;
      done_cnt++;
    end else begin
      bus.s_rx_done_valid = man_done;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_notify(input logic [15:0] sid, input logic [15:0] len);
    int rem;
    int c;
    req_t r;
    bus.s_notify_valid = 1'b1;
    bus.s_notify_sid   = sid;
    bus.s_notify_len   = len;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.s_notify_ready) break;
      step();
    end
    chk_eq("notify_accept", bus.s_notify_ready, 1);
    rem = len;
    while (rem > 0) begin
      c = (rem > PKG) ? PKG : rem;
      r.sid = sid;
      r.len = 16'(c);
      exp_q.push_back(r);
      rem -= c;
    end
    step();
    bus.s_notify_valid = 1'b0;
  endtask

  task automatic wait_valid();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.m_rd_pkg_valid) break;
      step();
    end
    chk_eq("wait_valid", bus.m_rd_pkg_valid, 1);
  endtask

  task automatic wait_idle(input int max);
    for (int n = 0; n < max; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && outstanding == 0 && !bus.m_rd_pkg_valid) break;
      step();
    end
    chk_eq("drain_left", exp_q.size(), 0);
    chk_eq("drain_outstanding", outstanding, 0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    areset             = 1'b1;
    bus.s_notify_valid = 1'b0;
    bus.s_notify_sid   = '0;
    bus.s_notify_len   = '0;
    bus.m_rd_pkg_ready = 1'b0;

    // Power-on reset
    repeat (3) begin
      step();
      @(negedge clk);
      chk_eq("rst_valid", bus.m_rd_pkg_valid, 0);
      chk_eq("rst_ready", bus.s_notify_ready, 0);
      chk_eq("rst_outstanding", outstanding, 0);
      chk_eq("rst_err", err_underflow, 0);
      chk_eq("rst_drop", drop_cnt, 0);
    end
    step();
    areset = 1'b0;
    @(negedge clk);
    chk_eq("post_rst_ready", bus.s_notify_ready, 1);
    chk_eq("post_rst_done_rdy", bus.s_rx_done_ready, 1);
    step();

    // Chunking with prompt done return and 2-cycle notify-to-request latency
    auto_done = 1'b1;
    bus.m_rd_pkg_ready = 1'b1;
    push_notify(16'd7, 16'd10000);
    @(negedge clk);
    chk_eq("lat_t1_valid", bus.m_rd_pkg_valid, 0);
    step();
    @(negedge clk);
    chk_eq("lat_t2_valid", bus.m_rd_pkg_valid, 1);
    chk_eq("lat_t2_len", bus.m_rd_pkg_len, 4096);
    step();
    wait_idle(100);

    // Credit stall at MAX_OUTSTANDING=2
    auto_done = 1'b0;
    hs0 = hs_cnt;
    push_notify(16'd9, 16'd20000);
    repeat (10) step();
    @(negedge clk);
    chk_eq("stall_hs", hs_cnt - hs0, 2);
    chk_eq("stall_valid", bus.m_rd_pkg_valid, 0);
    chk_eq("stall_outstanding", outstanding, 2);
    step();
    man_done = 1'b1;
    base++;
    step();
    man_done = 1'b0;
    @(negedge clk);
    chk_eq("credit_back_out", outstanding, 1);
    chk_eq("credit_back_valid", bus.m_rd_pkg_valid, 1);
    step();
    @(negedge clk);
    chk_eq("third_out", outstanding, 2);
    chk_eq("third_hs", hs_cnt - hs0, 3);
    chk_eq("third_valid", bus.m_rd_pkg_valid, 0);
    step();
    auto_done = 1'b1;
    wait_idle(200);

    // Zero-length drop, then underflow
    push_notify(16'd3, 16'd0);
    push_notify(16'd4, 16'd100);
    wait_idle(100);
    chk_eq("drop_cnt", drop_cnt, 1);
    chk_eq("no_err_yet", err_underflow, 0);
    auto_done = 1'b0;
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    @(negedge clk);
    chk_eq("underflow_err", err_underflow, 1);
    chk_eq("underflow_out", outstanding, 0);
    step();

    // Held request stays stable; issue and done in one cycle
    bus.m_rd_pkg_ready = 1'b0;
    push_notify(16'd5, 16'd5000);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      chk_eq("hold_sid", bus.m_rd_pkg_sid, 5);
      chk_eq("hold_len", bus.m_rd_pkg_len, 4096);
      chk_eq("hold_valid", bus.m_rd_pkg_valid, 1);
      step();
      @(negedge clk);
    end
    step();
    bus.m_rd_pkg_ready = 1'b1;
    step();
    man_done = 1'b1;
    base++;
    @(negedge clk);
    chk_eq("pre_simul_out", outstanding, 1);
    chk_eq("pre_simul_valid", bus.m_rd_pkg_valid, 1);
    step();
    man_done = 1'b0;
    @(negedge clk);
    chk_eq("simul_out", outstanding, 1);
    chk_eq("err_sticky", err_underflow, 1);
    step();
    auto_done = 1'b1;
    wait_idle(100);

    // Full notification queue behind a held request, then ordered drain
    auto_done = 1'b0;
    bus.m_rd_pkg_ready = 1'b0;
    hs0 = hs_cnt;
    push_notify(16'd200, 16'd100);
    wait_valid();
    step();
    for (int i = 0; i < 16; i++) begin
      push_notify(16'(100 + i), 16'd100);
    end
    bus.s_notify_valid = 1'b1;
    bus.s_notify_sid   = 16'd999;
    bus.s_notify_len   = 16'd50;
    repeat (3) begin
      @(negedge clk);
      chk_eq("full_ready", bus.s_notify_ready, 0);
      step();
    end
    bus.s_notify_valid = 1'b0;
    bus.m_rd_pkg_ready = 1'b1;
    auto_done = 1'b1;
    wait_idle(400);
    chk_eq("full_drain_hs", hs_cnt - hs0, 17);

    // Reset in the middle of a burst discards the work
    push_notify(16'd11, 16'd30000);
    repeat (4) step();
    auto_done = 1'b0;
    areset = 1'b1;
    exp_q.delete();
    repeat (3) begin
      step();
      @(negedge clk);
      chk_eq("mid_rst_valid", bus.m_rd_pkg_valid, 0);
      chk_eq("mid_rst_ready", bus.s_notify_ready, 0);
      chk_eq("mid_rst_out", outstanding, 0);
      chk_eq("mid_rst_err", err_underflow, 0);
      chk_eq("mid_rst_drop", drop_cnt, 0);
    end
    step();
    areset = 1'b0;
    base = hs_cnt - done_cnt;
    hs0 = hs_cnt;
    @(negedge clk);
    chk_eq("rel_ready", bus.s_notify_ready, 1);
    chk_eq("rel_valid", bus.m_rd_pkg_valid, 0);
    repeat (6) step();
    @(negedge clk);
    chk_eq("no_reissue_hs", hs_cnt - hs0, 0);
    chk_eq("no_reissue_valid", bus.m_rd_pkg_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
